// File: rtl/image_pkg.sv
// Shared types and defaults for the image capture block: frame geometry,
// derived index widths, FSM state encoding and the assembled pixel layout.
package image_pkg;
  localparam int N_DEF  = 64;
  localparam int M_DEF  = 64;
  localparam int XW_DEF = $clog2(N_DEF);
  localparam int YW_DEF = $clog2(M_DEF);
  localparam int AW_DEF = $clog2(N_DEF * M_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;
endpackage

// File: rtl/frame_buffer.sv
// Simple dual-port frame store: one write port, one registered read port.
// A read colliding with a write to the same address returns the old word.
module frame_buffer #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int W     = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/image_capture.sv
// Assembles an R,G,B byte stream into pixels of one N x M frame, strobes
// each pixel with its coordinates and stores it in a readable frame buffer.
module image_capture
  import image_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int M  = M_DEF,
  localparam int XW = $clog2(N),
  localparam int YW = $clog2(M),
  localparam int AW = $clog2(N * M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          camera_en,
  input  logic          data_valid,
  input  logic [7:0]    data_in,
  output logic          pixel_valid,
  output logic [23:0]   pixel_data,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          frame_done,
  output logic          busy,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data
);
  state_t        state, state_nxt;
  logic [1:0]    phase;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    r_q, g_q;
  logic          accept, pix_done, last_pix;
  logic [AW-1:0] wr_addr;
  pixel_t        wr_pix;

  assign accept   = (state == CAPTURE) && data_valid;
  assign pix_done = accept && (phase == 2'd2);
  assign last_pix = (x == XW'(N - 1)) && (y == YW'(M - 1));
  assign wr_pix   = {r_q, g_q, data_in};
  assign wr_addr  = AW'(y) * AW'(N) + AW'(x);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    camera_en = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: begin
        camera_en = 1'b1;
        busy      = 1'b1;
        if (pix_done && last_pix) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase       <= 2'd0;
      x           <= '0;
      y           <= '0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      pixel_data  <= 24'd0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      pixel_valid <= pix_done;
      frame_done  <= pix_done && last_pix;
      if (pix_done) begin
        pixel_data <= wr_pix;
        pixel_x    <= x;
        pixel_y    <= y;
      end
      // Outside CAPTURE the position is parked at the frame origin so any
      // new frame starts clean, even after an abandoned one.
      if (state != CAPTURE) begin
        phase <= 2'd0;
        x     <= '0;
        y     <= '0;
      end else if (accept) begin
        case (phase)
          2'd0:    begin r_q <= data_in; phase <= 2'd1; end
          2'd1:    begin g_q <= data_in; phase <= 2'd2; end
          default: begin
            phase <= 2'd0;
            if (x == XW'(N - 1)) begin
              x <= '0;
              y <= (y == YW'(M - 1)) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        endcase
      end
    end
  end

  frame_buffer #(.DEPTH(N * M), .AW(AW), .W(24)) u_fb (
    .clk   (clk),
    .we    (pix_done),
    .waddr (wr_addr),
    .wdata (wr_pix),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_image_capture.sv
// Scoreboard bench for image_capture: the stimulus pushes expected pixels,
// a negedge monitor pops and compares whenever pixel_valid is seen.
module tb_image_capture;
  localparam int N = 64, M = 64, NPIX = N * M, NBYTES = 3 * NPIX;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, data_valid = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic [11:0] rd_addr = 12'd0;
  logic        camera_en, pixel_valid, frame_done, busy;
  logic [23:0] pixel_data, rd_data;
  logic [5:0]  pixel_x, pixel_y;

  always #5 clk = ~clk;

  image_capture #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .camera_en(camera_en),
    .data_valid(data_valid), .data_in(data_in), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_done(frame_done), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  logic [36:0] exp_q[$];
  logic [36:0] e;
  int vectors = 0, miscompares = 0, pix_cnt = 0, fd_cnt = 0;
  logic [23:0] first_pix = '0;
  logic [5:0]  first_x = '0, first_y = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {frame_done, y, x, R, G, B} for pixel p of a stream where byte k = k mod 256
  function automatic logic [36:0] exp_pixel(input int p);
    logic [7:0] r = 8'(3 * p), g = 8'(3 * p + 1), b = 8'(3 * p + 2);
    return {p == NPIX - 1, 6'(p / N), 6'(p % N), r, g, b};
  endfunction

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pixel: got pixel 0x%0h at (%0d,%0d), expected none",
                 pixel_data, pixel_x, pixel_y);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {frame_done, pixel_y, pixel_x, pixel_data}, {27'd0, e});
      end
      if (pix_cnt == 0) begin
        first_pix = pixel_data; first_x = pixel_x; first_y = pixel_y;
      end
      pix_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check_reset();
    check("rst_camera_en", camera_en, 0);
    check("rst_busy", busy, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pixel", {pixel_y, pixel_x, pixel_data}, 0);
  endtask

  task automatic do_start(input bit junk_dv);
    @(negedge clk); start = 1'b1; data_valid = junk_dv; data_in = 8'hAA;
    @(negedge clk); start = 1'b0; data_valid = 1'b0;
    check("camera_en_after_start", camera_en, 1);
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int nbytes, input int gap_after, input int gap_len, input int start_at);
    for (int k = 0; k < nbytes; k++) begin
      @(negedge clk);
      data_valid = 1'b1; data_in = 8'(k); start = (k == start_at);
      if (k % 3 == 2) exp_q.push_back(exp_pixel(k / 3));
      if (k == gap_after)
        repeat (gap_len) begin
          @(negedge clk); data_valid = 1'b0; data_in = 8'hEE; start = 1'b0;
        end
    end
    @(negedge clk); data_valid = 1'b0; start = 1'b0;
  endtask

  // Called in the DONE cycle; optionally starts the next frame in the IDLE cycle.
  task automatic end_frame(input bit chain);
    check("camera_en_done", camera_en, 0);
    check("busy_done", busy, 0);
    @(negedge clk);
    check("frame_done_count", fd_cnt, 1);
    check("pixel_count", pix_cnt, NPIX);
    check("first_pixel", {first_y, first_x, first_pix}, {6'd0, 6'd0, 24'h000102});
    pix_cnt = 0; fd_cnt = 0;
    if (chain) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("camera_en_chain", camera_en, 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    // continuous frame
    do_start(1'b0);
    feed(NBYTES, -1, 0, -1);
    end_frame(1'b0);

    @(negedge clk); rd_addr = 12'd65;
    @(negedge clk); check("rd_65", rd_data, 24'hC3C4C5); rd_addr = 12'd0;
    @(negedge clk); check("rd_0", rd_data, 24'h000102); rd_addr = 12'd4095;
    @(negedge clk); check("rd_4095", rd_data, 24'hFDFEFF);

    // bytes while IDLE are ignored
    repeat (6) begin
      @(negedge clk); data_valid = 1'b1; data_in = 8'($urandom);
      check("idle_camera_en", camera_en, 0);
      check("idle_pixel_valid", pixel_valid, 0);
    end
    data_valid = 1'b0;

    // mid-pixel gap, junk byte on the start cycle, start pulse mid-capture
    do_start(1'b1);
    feed(NBYTES, 1, 5, 600);
    end_frame(1'b0);

    // abort after 100 bytes, then a fresh frame
    do_start(1'b0);
    feed(100, -1, 0, -1);
    repeat (3) @(negedge clk);
    check("abort_pixels", pix_cnt, 33);
    check("abort_queue", exp_q.size(), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    pix_cnt = 0; fd_cnt = 0; exp_q.delete();

    // back-to-back frames: start in the IDLE cycle right after DONE
    do_start(1'b0);
    feed(NBYTES, -1, 0, -1);
    end_frame(1'b1);
    feed(NBYTES, -1, 0, -1);
    end_frame(1'b0);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
